// File: rtl/hand_presence_filter.sv
// hand_presence_filter
//   Turns the raw photoresistor input into a clean hand-present level plus
//   one-cycle edge pulses for the dispenser controller.
//   Chain: 2-flop synchroniser -> sample-tick divider -> saturating integrator
//   -> hysteresis + minimum-dwell two-state FSM.
// Ports
//   clk_1M        in   1      system clock, all logic on rising edge
//   rst           in   1      synchronous active-high reset
//   pr0           in   1      raw photoresistor, asynchronous, 0 = hand present
//   present       out  1      filtered hand-present level
//   present_rise  out  1      one-cycle pulse on ABSENT->PRESENT
//   present_fall  out  1      one-cycle pulse on PRESENT->ABSENT
//   lvl           out  LVL_W  integrator value (telemetry)
module hand_presence_filter #(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned LVL_W      = 10,
    parameter int unsigned LVL_MAX    = 1000,
    parameter int unsigned ON_THRESH  = 750,
    parameter int unsigned OFF_THRESH = 250,
    parameter int unsigned MIN_DWELL  = 200
) (
    input  logic             clk_1M,
    input  logic             rst,
    input  logic             pr0,
    output logic             present,
    output logic             present_rise,
    output logic             present_fall,
    output logic [LVL_W-1:0] lvl
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = $clog2(MIN_DWELL + 1);

    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_TOP   = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0] ON_LVL    = LVL_W'(ON_THRESH);
    localparam logic [LVL_W-1:0] OFF_LVL   = LVL_W'(OFF_THRESH);
    localparam logic [DW-1:0]    DWELL_TOP = DW'(MIN_DWELL);

    typedef enum logic {StAbsent, StPresent} state_e;

    logic             pr0_s1_q, pr0_s2_q;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    state_e           state_q, state_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             tick;
    logic             hand;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        hand       = ~pr0_s2_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        // Integrator moves one step per sample tick, clamped at both ends.
        lvl_d = lvl_q;
        if (tick) begin
            if (hand && (lvl_q < LVL_TOP)) begin
                lvl_d = lvl_q + 1'b1;
            end else if (!hand && (lvl_q != '0)) begin
                lvl_d = lvl_q - 1'b1;
            end
        end

        // Transitions look at registered lvl, so a same-cycle tick update is not seen yet.
        state_d = state_q;
        case (state_q)
            StAbsent: begin
                if ((lvl_q > ON_LVL) && (dwell_q == DWELL_TOP)) state_d = StPresent;
            end
            StPresent: begin
                if ((lvl_q < OFF_LVL) && (dwell_q == DWELL_TOP)) state_d = StAbsent;
            end
            default: state_d = StAbsent;
        endcase

        // A state change restarts the dwell window and swallows any coincident tick.
        dwell_d = dwell_q;
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (tick && (dwell_q != DWELL_TOP)) begin
            dwell_d = dwell_q + 1'b1;
        end

        rise_d = (state_q == StAbsent) && (state_d == StPresent);
        fall_d = (state_q == StPresent) && (state_d == StAbsent);
    end

    always_ff @(posedge clk_1M) begin
        if (rst) begin
            pr0_s1_q   <= 1'b1;
            pr0_s2_q   <= 1'b1;
            tick_cnt_q <= '0;
            lvl_q      <= '0;
            dwell_q    <= '0;
            state_q    <= StAbsent;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            pr0_s1_q   <= pr0;
            pr0_s2_q   <= pr0_s1_q;
            tick_cnt_q <= tick_cnt_d;
            lvl_q      <= lvl_d;
            dwell_q    <= dwell_d;
            state_q    <= state_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign present      = (state_q == StPresent);
    assign present_rise = rise_q;
    assign present_fall = fall_q;
    assign lvl          = lvl_q;

endmodule
